strng_harvest: RTL and testbench
================================

STRNG_HARVEST -- requirements
Module: strng_harvest

Interface
REQ-001 Parameter STR_LEN, default 8, width of the raw random bus from the STR core.
REQ-002 Parameter WORD_W, default 32, width of each harvested output word.
REQ-003 Parameter FIFO_DEPTH, default 4, number of buffered words; power of two, at least 2.
REQ-004 Parameter WARMUP_CYC, default 64, number of discarded sample cycles after enable.
REQ-005 clk  input  1  sample clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  harvest enable.
REQ-008 rnd_data  input  STR_LEN  raw random bus from the STR core, already synchronous to clk.
REQ-009 out_valid  output  1  FIFO head word available.
REQ-010 out_ready  input  1  consumer accepts the head word.
REQ-011 out_data  output  WORD_W  FIFO head word.
REQ-012 ovf  output  1  sticky flag: a completed word was dropped.
REQ-013 ovf_clr  input  1  clears ovf.
REQ-014 busy  output  1  high in the WARMUP and RUN states.

Function
REQ-015 The raw bit SHALL be computed each cycle as the XOR-reduction of rnd_data.
REQ-016 The controller SHALL have three states:
- IDLE: reset state; en=1 moves to WARMUP.
- WARMUP: counts WARMUP_CYC cycles, then moves to RUN.
- RUN: harvests bits.
- From WARMUP or RUN, en=0 returns to IDLE on the next edge.
REQ-017 In WARMUP, raw bits SHALL be discarded. WARMUP_CYC=0 SHALL go from IDLE directly to RUN.
REQ-018 In RUN, every cycle SHALL produce one candidate raw bit (Configuration rules apply).
REQ-019 Accepted bits SHALL fill the word LSB-first: the first accepted bit goes to bit 0 and the WORD_W-th to bit WORD_W-1.
REQ-020 On the cycle the WORD_W-th bit is accepted, the word SHALL be pushed, and the bit counter SHALL wrap to 0 with no lost cycle.
REQ-021 Entering IDLE SHALL clear the partial word, the bit counter, the warmup counter and the pair state; FIFO contents SHALL be retained.
REQ-022 The FIFO SHALL be first-word-fall-through.
- out_valid SHALL equal FIFO not-empty.
- A pop SHALL occur when out_valid and out_ready are both high.
- out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 A pushed word SHALL appear on out_data, with out_valid=1, on the cycle after the push edge.
REQ-024 A push when full with a simultaneous pop SHALL succeed; a push when full without a pop SHALL drop the new word and set ovf.
REQ-025 A simultaneous push and pop when empty SHALL NOT occur, because out_valid=0 at that time.
REQ-026 ovf_clr SHALL clear ovf; if ovf_clr and a drop occur on the same cycle, the set SHALL win.
REQ-027 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-028 rst SHALL force the following, regardless of en:
- state IDLE;
- all counters, the shift register and the pair state to 0;
- FIFO empty;
- out_valid=0, out_data=0, ovf=0, busy=0.
REQ-029 Reset mid-word or mid-warmup SHALL discard all in-flight bits and buffered words.

Configuration
REQ-030 With STRNG_VN_DEBIAS_EN defined, RUN bits SHALL be processed as von Neumann pairs: consecutive raw bits (a, b), with a first.
- 01 SHALL emit 0; 10 SHALL emit 1; 00 and 11 SHALL emit nothing.
- Pairs SHALL NOT overlap.
REQ-031 Without STRNG_VN_DEBIAS_EN, every RUN raw bit SHALL be accepted, and the pair logic SHALL be absent.

Structure
REQ-032 A shared package SHALL hold:
- the state encoding (IDLE=2'd0, WARMUP=2'd1, RUN=2'd2);
- the default parameter values.
REQ-033 The FIFO SHALL be a sub-module, strng_fifo, parameterized by width and depth, with push/pop/full/empty ports.

Verification
REQ-034 Warmup timing, no VN, WARMUP_CYC=4, WORD_W=32:
- stimulus: en=1 from cycle 0, XOR-reduced rnd_data constant 1;
- response: busy=1 from cycle 1, first push at the RUN entry+31 edge, out_valid=1 one cycle later, out_data=32'hFFFF_FFFF.
REQ-035 VN decoding, with STRNG_VN_DEBIAS_EN:
- stimulus: raw sequence 01,10,00,11 repeated;
- response: one word accepted per 128 RUN cycles, out_data=32'hAAAA_AAAA.
REQ-036 Overflow, FIFO_DEPTH=4:
- stimulus: out_ready=0, 5 words harvested;
- response: FIFO holds words 1-4, ovf=1 after the 5th push edge; ovf_clr pulse gives ovf=0.
REQ-037 Full-FIFO push with pop:
- stimulus: out_ready held 1 on the cycle a 5th word completes;
- response: no drop, ovf=0, words read in order.
REQ-038 Enable drop mid-word:
- stimulus: en=0 after 10 accepted bits, then en=1;
- response: state IDLE, then a full warmup; the next word contains no stale bits and buffered words are intact.
REQ-039 Synchronous reset:
- stimulus: rst=1 for one cycle with 2 words buffered;
- response: out_valid=0, out_data=0, ovf=0, busy=0 on the next edge.

Source files
------------

// File: rtl/strng_harvest_pkg.sv
// strng_harvest_pkg: controller state encoding and default parameter values
package strng_harvest_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2} state_e;
    localparam int STR_LEN_DEF    = 8;
    localparam int WORD_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WARMUP_CYC_DEF = 64;
endpackage

// File: rtl/strng_fifo.sv
// strng_fifo: first-word-fall-through FIFO, head reads as zero when empty
module strng_fifo
    import strng_harvest_pkg::*;
#(
    parameter int WIDTH = WORD_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic wr_en, rd_en;
    always_comb begin
        empty = cnt_q == '0;
        full  = cnt_q == CW'(DEPTH);
        rd_en = pop && !empty;
        // a full FIFO still accepts a word when the head leaves on the same edge
        wr_en = push && (!full || rd_en);
        dout  = empty ? '0 : mem_q[rd_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (rd_en) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end
endmodule

// File: rtl/strng_harvest.sv
// strng_harvest: packs XOR-reduced STR bits LSB-first into words behind a FWFT FIFO; STRNG_VN_DEBIAS_EN adds von Neumann debiasing
module strng_harvest
    import strng_harvest_pkg::*;
#(
    parameter int STR_LEN    = STR_LEN_DEF,
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int WARMUP_CYC = WARMUP_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [STR_LEN-1:0] rnd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               ovf,
    input  logic               ovf_clr,
    output logic               busy
);
    localparam int WCW = WARMUP_CYC > 1 ? $clog2(WARMUP_CYC) : 1;
    localparam int BCW = $clog2(WORD_W);
    state_e state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [WORD_W-1:0] word_q, word_d, push_word;
    logic ovf_q, ovf_d;
    logic raw, harvest, acc, acc_bit, push, pop, full, empty;
    assign raw     = ^rnd_data;
    assign harvest = state_q == RUN && en;
    always_comb begin
        state_d = state_q;
        if (!en) state_d = IDLE;
        else if (state_q == IDLE) state_d = WARMUP_CYC == 0 ? RUN : WARMUP;
        else if (state_q == WARMUP && wcnt_q == WCW'(WARMUP_CYC - 1)) state_d = RUN;
    end
`ifdef STRNG_VN_DEBIAS_EN
    logic pair_q, pair_d, a_q, a_d;
    // first bit of a pair is parked in a_q; the pair emits a_q only when the bits differ
    always_comb begin
        pair_d  = state_d == IDLE ? 1'b0 : harvest ? ~pair_q : pair_q;
        a_d     = state_d == IDLE ? 1'b0 : harvest && !pair_q ? raw : a_q;
        acc     = harvest && pair_q && (a_q ^ raw);
        acc_bit = a_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q <= 1'b0;
            a_q    <= 1'b0;
        end else begin
            pair_q <= pair_d;
            a_q    <= a_d;
        end
    end
`else
    assign acc     = harvest;
    assign acc_bit = raw;
`endif
    always_comb begin
        push_word = {acc_bit, word_q[WORD_W-1:1]};
        push      = acc && bcnt_q == BCW'(WORD_W - 1);
        pop       = out_valid && out_ready;
        wcnt_d    = state_q == WARMUP && state_d == WARMUP ? wcnt_q + 1'b1 : '0;
        word_d    = state_d == IDLE || push ? '0 : acc ? push_word : word_q;
        bcnt_d    = state_d == IDLE || push ? '0 : acc ? bcnt_q + 1'b1 : bcnt_q;
        ovf_d     = push && full && !pop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end
    strng_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (push_word),
        .dout (out_data),
        .full (full),
        .empty(empty)
    );
    assign out_valid = !empty;
    assign ovf       = ovf_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_strng_harvest.sv
// tb_strng_harvest: word table plus hand sequences, checked against a FIFO/ovf scoreboard model
module tb_strng_harvest;
    localparam int WU = 4;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 1, en = 0, out_ready = 0, ovf_clr = 0;
    logic [7:0] rnd_data = '0;
    logic out_valid, ovf, busy;
    logic [31:0] out_data;
    logic [31:0] exp_q[$];
    logic exp_ovf = 0;
    bit push_pend = 0;
    logic [31:0] pend_word = '0;
    int n_tests = 0, n_fail = 0;
    typedef struct {logic [31:0] word; bit ready;} vec_t;
    vec_t tbl[6];
    strng_harvest #(.STR_LEN(8), .WORD_W(32), .FIFO_DEPTH(DEPTH), .WARMUP_CYC(WU)) dut (
        .clk(clk), .rst(rst), .en(en), .rnd_data(rnd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [7:0] mk(input logic b);
        logic [7:0] r;
        r = 8'($urandom);
        if ((^r) != b) r[0] = ~r[0];
        return r;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // model: outputs checked mid-cycle, then state advanced for the coming edge
    task automatic monitor();
        bit drop;
        forever begin
            @(negedge clk);
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
            else check("out_data_idle", out_data, 32'h0);
            check("ovf", 32'(ovf), 32'(exp_ovf));
            if (rst) begin
                exp_q.delete();
                exp_ovf = 0;
            end else begin
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                drop = 0;
                if (push_pend) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(pend_word);
                    else drop = 1;
                end
                exp_ovf = drop ? 1'b1 : ovf_clr ? 1'b0 : exp_ovf;
            end
        end
    endtask
    task automatic drive_raw(input logic b, input bit last, input logic [31:0] w, input bit rdy);
        rnd_data = mk(b);
        if (last) begin
            push_pend = 1;
            pend_word = w;
            if (rdy) out_ready = 1;
        end
        tick();
        push_pend = 0;
    endtask
    task automatic drive_word(input logic [31:0] w, input int n, input bit rdy);
        bit last;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1) && (n == 32);
`ifdef STRNG_VN_DEBIAS_EN
            drive_raw(w[i], 1'b0, w, 1'b0);
            drive_raw(~w[i], last, w, rdy);
            if (i % 2 == 1 && !last) begin
                drive_raw(i[1], 1'b0, w, 1'b0);
                drive_raw(i[1], 1'b0, w, 1'b0);
            end
`else
            drive_raw(w[i], last, w, rdy);
`endif
        end
    endtask
    task automatic start_run();
        check("busy_before_en", 32'(busy), 32'h0);
        en = 1;
        rnd_data = 8'($urandom);
        tick();
        check("busy_after_en", 32'(busy), 32'h1);
        repeat (WU) begin
            rnd_data = 8'($urandom);
            tick();
        end
    endtask
    task automatic stop_and_drain();
        en = 0;
        tick();
        out_ready = 1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check("drain_timeout", 32'(exp_q.size()), 32'h0);
        out_ready = 0;
    endtask
    initial begin
        tbl[0] = '{32'hFFFF_FFFF, 1'b1};
        tbl[1] = '{32'h0000_0000, 1'b1};
        tbl[2] = '{32'hAAAA_AAAA, 1'b1};
        tbl[3] = '{32'h1234_5678, 1'b0};
        tbl[4] = '{32'hDEAD_BEEF, 1'b1};
        tbl[5] = '{32'h8000_0001, 1'b1};
        en = 1;
        tick();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        en = 0;
        fork monitor(); join_none
        tick();
        rst = 0;
        tick();
        // word table, back to back in one RUN period
        start_run();
        for (int k = 0; k < 6; k++) begin
            out_ready = tbl[k].ready;
            drive_word(tbl[k].word, 32, 1'b0);
        end
        stop_and_drain();
        // overflow: five words into a four-deep FIFO with no reader
        start_run();
        for (int k = 0; k < 5; k++) drive_word(32'h1111_1111 * (k + 1), 32, 1'b0);
        en = 0;
        tick();
        check("ovf_set", 32'(ovf), 32'h1);
        check("ovf_head", out_data, 32'h1111_1111);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        check("ovf_clr", 32'(ovf), 32'h0);
        stop_and_drain();
        // full FIFO: reader pops on the same edge the fifth word lands
        start_run();
        for (int k = 0; k < 4; k++) drive_word(32'hA5A5_0000 + k, 32, 1'b0);
        drive_word(32'h5A5A_0004, 32, 1'b1);
        en = 0;
        tick();
        check("push_pop_full_ovf", 32'(ovf), 32'h0);
        stop_and_drain();
        // enable dropped mid-word: partial bits discarded, buffered words kept
        start_run();
        drive_word(32'h0F0F_0F0F, 32, 1'b0);
        drive_word(32'h3333_CCCC, 32, 1'b0);
        drive_word(32'hFFFF_FFFF, 10, 1'b0);
        en = 0;
        tick();
        check("en_drop_busy", 32'(busy), 32'h0);
        check("en_drop_valid", 32'(out_valid), 32'h1);
        start_run();
        drive_word(32'hC0FF_EE11, 32, 1'b0);
        stop_and_drain();
        // synchronous reset with two buffered words, en held high
        start_run();
        drive_word(32'h7777_0001, 32, 1'b0);
        drive_word(32'h7777_0002, 32, 1'b0);
        rst = 1;
        tick();
        rst = 0;
        en = 0;
        check("srst_valid", 32'(out_valid), 32'h0);
        check("srst_data", out_data, 32'h0);
        check("srst_ovf", 32'(ovf), 32'h0);
        check("srst_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
